// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: miss-service engine that writes back a dirty victim line
// and refills the missing line word-by-word between the bus and cache data RAM.
module cache_line_fill_ctrl #(
    parameter int TAG_WID      = 14,
    parameter int ENTRYSEL_WID = 4,
    parameter int LINE_WORDS   = 4,
    parameter int WORDSEL_WID  = $clog2(LINE_WORDS),
    parameter int ADDR_WID     = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                line_miss,
    input  logic                                replace_dirty,
    input  logic [TAG_WID-1:0]                  miss_tag,
    input  logic [ENTRYSEL_WID-1:0]             miss_ent,
    input  logic [TAG_WID-1:0]                  victim_tag,
    input  logic                                flush_req,
    output logic                                line_refill,
    output logic [TAG_WID-1:0]                  refill_tag,
    output logic                                writeback_ok,
    output logic                                valid_clear,
    output logic                                busy,
    output logic                                cmem_we,
    output logic [ENTRYSEL_WID+WORDSEL_WID-1:0] cmem_addr,
    output logic [31:0]                         cmem_wdata,
    input  logic [31:0]                         cmem_rdata,
    output logic                                bus_req,
    output logic                                bus_we,
    output logic [ADDR_WID-1:0]                 bus_addr,
    output logic [31:0]                         bus_wdata,
    input  logic [31:0]                         bus_rdata,
    input  logic                                bus_ack
);
    typedef enum logic [2:0] {IDLE, WB_RD, WB_LAT, WB_BUS, WB_DONE, RF_BUS, RF_DONE, FLUSH} state_t;
    state_t                  state;
    logic [TAG_WID-1:0]      tag, vtag;
    logic [ENTRYSEL_WID-1:0] ent;
    logic [WORDSEL_WID-1:0]  cnt;
    logic [31:0]             buffer;
    logic                    last, wb_bus, rf_bus;
    logic [TAG_WID+ENTRYSEL_WID+WORDSEL_WID+1:0] beat_addr;
    assign last   = cnt == WORDSEL_WID'(LINE_WORDS - 1);
    assign wb_bus = state == WB_BUS;
    assign rf_bus = state == RF_BUS;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tag    <= '0;
            vtag   <= '0;
            ent    <= '0;
            cnt    <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        ent   <= miss_ent;
                        state <= FLUSH;
                    end else if (line_miss) begin
                        ent   <= miss_ent;
                        tag   <= miss_tag;
                        vtag  <= victim_tag;
                        cnt   <= '0;
                        state <= replace_dirty ? WB_RD : RF_BUS;
                    end
                end
                WB_RD:  state <= WB_LAT;
                WB_LAT: begin
                    buffer <= cmem_rdata;
                    state  <= WB_BUS;
                end
                // LINE_WORDS is a power of two, so the counter wraps to 0 on its own
                WB_BUS: if (bus_ack) begin
                    cnt   <= cnt + 1'b1;
                    state <= last ? WB_DONE : WB_RD;
                end
                WB_DONE: state <= RF_BUS;
                RF_BUS: if (bus_ack) begin
                    cnt   <= cnt + 1'b1;
                    state <= last ? RF_DONE : RF_BUS;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        beat_addr    = {wb_bus ? vtag : tag, ent, cnt, 2'b00};
        busy         = state != IDLE;
        bus_req      = wb_bus | rf_bus;
        bus_we       = wb_bus;
        bus_addr     = bus_req ? ADDR_WID'(beat_addr) : '0;
        bus_wdata    = wb_bus ? buffer : '0;
        cmem_we      = rf_bus & bus_ack;
        cmem_addr    = (state == WB_RD || rf_bus) ? {ent, cnt} : '0;
        cmem_wdata   = rf_bus ? bus_rdata : '0;
        line_refill  = state == RF_DONE;
        refill_tag   = line_refill ? tag : '0;
        writeback_ok = state == WB_DONE;
        valid_clear  = state == FLUSH;
    end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// tb_cache_line_fill_ctrl: directed bench with bus/RAM models and hand-computed
// beat addresses, data and latencies.
module tb_cache_line_fill_ctrl;
    logic        clk = 0, rst = 0, line_miss = 0, replace_dirty = 0, flush_req = 0;
    logic [13:0] miss_tag = 0, victim_tag = 0;
    logic [3:0]  miss_ent = 0;
    logic        line_refill, writeback_ok, valid_clear, busy, cmem_we, bus_req, bus_we, bus_ack;
    logic [13:0] refill_tag;
    logic [5:0]  cmem_addr;
    logic [31:0] cmem_wdata, cmem_rdata, bus_addr, bus_wdata, bus_rdata;

    cache_line_fill_ctrl dut (
        .clk(clk), .rst(rst), .line_miss(line_miss), .replace_dirty(replace_dirty),
        .miss_tag(miss_tag), .miss_ent(miss_ent), .victim_tag(victim_tag), .flush_req(flush_req),
        .line_refill(line_refill), .refill_tag(refill_tag), .writeback_ok(writeback_ok),
        .valid_clear(valid_clear), .busy(busy), .cmem_we(cmem_we), .cmem_addr(cmem_addr),
        .cmem_wdata(cmem_wdata), .cmem_rdata(cmem_rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial forever #5 clk = ~clk;

    // bus slave: ack after `waits` stall cycles, read data chosen by word index
    int          waits = 0;
    int          wcnt = 0;
    logic [31:0] rdt [0:3];
    assign bus_ack   = bus_req && (wcnt == waits);
    assign bus_rdata = bus_req ? rdt[bus_addr[3:2]] : 32'h0;
    always @(posedge clk) wcnt <= (bus_req && !bus_ack) ? wcnt + 1 : 0;

    // cache data RAM with one-cycle read latency and a bench preload port
    logic        ld = 0;
    logic [5:0]  ld_a = 0;
    logic [31:0] ld_d = 0;
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (cmem_we) mem[cmem_addr] <= cmem_wdata;
        cmem_rdata <= mem[cmem_addr];
    end

    // mid-cycle monitor: logs completed beats, RAM writes, pulses, bus stability
    logic [31:0] ba [0:63], bd [0:63], cd [0:63];
    logic        bw [0:63];
    logic [5:0]  ca [0:63];
    logic [13:0] rt [0:63];
    int nb = 0, nc = 0, nlr = 0, nwb = 0, nvc = 0, nreq = 0, nviol = 0;
    logic        pend = 0, pwe = 0;
    logic [31:0] paddr = 0;
    always @(negedge clk) begin
        if (bus_req && bus_ack) begin
            ba[6'(nb)] <= bus_addr;
            bw[6'(nb)] <= bus_we;
            bd[6'(nb)] <= bus_we ? bus_wdata : bus_rdata;
            nb <= nb + 1;
        end
        if (cmem_we) begin
            ca[6'(nc)] <= cmem_addr;
            cd[6'(nc)] <= cmem_wdata;
            nc <= nc + 1;
        end
        if (line_refill) begin
            rt[6'(nlr)] <= refill_tag;
            nlr <= nlr + 1;
        end
        if (writeback_ok) nwb <= nwb + 1;
        if (valid_clear) nvc <= nvc + 1;
        if (bus_req) nreq <= nreq + 1;
        if (pend && (!bus_req || bus_addr != paddr || bus_we != pwe)) nviol <= nviol + 1;
        pend  <= bus_req && !bus_ack;
        paddr <= bus_addr;
        pwe   <= bus_we;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beats(input string tag, input int base, input int n, input logic we,
                             input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] ds);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, ba[6'(base + i)], a0 + 32'(4 * i));
            chk({tag, "_we"}, 32'(bw[6'(base + i)]), 32'(we));
            chk({tag, "_data"}, bd[6'(base + i)], d0 + ds * 32'(i));
        end
    endtask

    task automatic chk_cmem(input string tag, input int base, input logic [5:0] a0,
                            input logic [31:0] d0, input logic [31:0] ds);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_caddr"}, 32'(ca[6'(base + i)]), 32'(a0) + 32'(i));
            chk({tag, "_cdata"}, cd[6'(base + i)], d0 + ds * 32'(i));
        end
    endtask

    task automatic set_rdt(input logic [31:0] d0, input logic [31:0] ds);
        for (int i = 0; i < 4; i++) rdt[i] = d0 + ds * 32'(i);
    endtask

    task automatic issue(input logic [3:0] e, input logic [13:0] t, input logic d,
                         input logic [13:0] v, input logic f);
        @(negedge clk);
        miss_ent = e; miss_tag = t; replace_dirty = d; victim_tag = v; flush_req = f; line_miss = 1;
    endtask

    // returns cycles from the IDLE cycle that sampled the request to line_refill
    task automatic wait_refill(output int lat);
        @(negedge clk);
        line_miss = 0; replace_dirty = 0; flush_req = 0;
        lat = 1;
        while (!line_refill && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, b, c, l, q, w, v;
        set_rdt(32'h11, 32'h11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld = 1; ld_a = 6'(8 + i); ld_d = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        ld = 0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_cmem_addr", 32'(cmem_addr), 0);
        chk("rst_cmem_we", 32'(cmem_we), 0);
        chk("rst_line_refill", 32'(line_refill), 0);
        chk("rst_refill_tag", 32'(refill_tag), 0);
        chk("rst_pulses", {29'h0, writeback_ok, valid_clear, bus_we}, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // clean miss, zero-wait
        b = nb; c = nc; l = nlr;
        issue(4'd3, 14'h0A5, 1'b0, 14'h0, 1'b0);
        wait_refill(lat);
        chk("clean_lat", 32'(lat), 5);
        chk("clean_tag", 32'(refill_tag), 32'h0A5);
        chk("clean_nbeats", 32'(nb - b), 4);
        chk_beats("clean", b, 4, 1'b0, 32'h0A530, 32'h11, 32'h11);
        chk_cmem("clean", c, 6'd12, 32'h11, 32'h11);
        @(negedge clk);
        chk("clean_done_idle", 32'(busy), 0);

        // dirty miss: write back ent 2 (RAM words A0..A3), then refill
        set_rdt(32'h55, 32'h11);
        b = nb; c = nc; w = nwb;
        issue(4'd2, 14'h0B0, 1'b1, 14'h001, 1'b0);
        wait_refill(lat);
        #1;
        chk("dirty_lat", 32'(lat), 18);
        chk("dirty_tag", 32'(refill_tag), 32'h0B0);
        chk("dirty_wb_ok", 32'(nwb - w), 1);
        chk("dirty_nbeats", 32'(nb - b), 8);
        chk_beats("dirty_wr", b, 4, 1'b1, 32'h00120, 32'hA0, 32'h1);
        chk_beats("dirty_rd", b + 4, 4, 1'b0, 32'h0B020, 32'h55, 32'h11);
        chk_cmem("dirty", c, 6'd8, 32'h55, 32'h11);

        // two wait states per beat
        set_rdt(32'h11, 32'h11);
        waits = 2;
        b = nb; v = nviol;
        issue(4'd5, 14'h2C3, 1'b0, 14'h0, 1'b0);
        wait_refill(lat);
        chk("wait_lat", 32'(lat), 13);
        chk("wait_stable", 32'(nviol - v), 0);
        chk("wait_nbeats", 32'(nb - b), 4);
        chk_beats("wait", b, 4, 1'b0, 32'h2C350, 32'h11, 32'h11);
        waits = 0;

        // flush wins over a simultaneous miss; miss then serviced from IDLE
        b = nb; q = nreq; v = nvc;
        issue(4'd7, 14'h123, 1'b0, 14'h0, 1'b1);
        @(negedge clk);
        chk("flush_vclear", 32'(valid_clear), 1);
        chk("flush_busy", 32'(busy), 1);
        flush_req = 0;
        @(negedge clk);
        chk("flush_vclear_once", 32'(valid_clear), 0);
        chk("flush_idle", 32'(busy), 0);
        chk("flush_no_bus", 32'(nreq - q), 0);
        chk("flush_vc_count", 32'(nvc - v), 1);
        wait_refill(lat);
        chk("flush_miss_lat", 32'(lat), 5);
        chk_beats("flush_miss", b, 1, 1'b0, 32'h12370, 32'h11, 32'h11);

        // reset during beat 2 of a refill
        @(negedge clk);
        l = nlr;
        issue(4'd4, 14'h055, 1'b0, 14'h0, 1'b0);
        @(negedge clk);
        line_miss = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_in_beat", 32'(bus_req), 1);
        #1 rst = 0;
        #1;
        chk("rstmid_bus_req", 32'(bus_req), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_cmem_we", 32'(cmem_we), 0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rstmid_no_refill", 32'(nlr - l), 0);
        b = nb;
        issue(4'd4, 14'h055, 1'b0, 14'h0, 1'b0);
        wait_refill(lat);
        chk("rstmid_relat", 32'(lat), 5);
        chk_beats("rstmid_restart", b, 1, 1'b0, 32'h05540, 32'h11, 32'h11);

        // back-to-back misses with a single IDLE cycle between them
        @(negedge clk);
        l = nlr;
        issue(4'd0, 14'h100, 1'b0, 14'h0, 1'b0);
        wait_refill(lat);
        chk("b2b_lat0", 32'(lat), 5);
        miss_ent = 4'd1; miss_tag = 14'h200; line_miss = 1;
        @(negedge clk);
        chk("b2b_idle_gap", 32'(busy), 0);
        wait_refill(lat);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_lat1", 32'(lat), 5);
        @(negedge clk);
        #1;
        chk("b2b_nrefill", 32'(nlr - l), 2);
        chk("b2b_tag0", 32'(rt[6'(l)]), 32'h100);
        chk("b2b_tag1", 32'(rt[6'(l + 1)]), 32'h200);
        chk("end_idle_addr", bus_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
